// File: rtl/wb_if.sv
// Wishbone B4 bus bundle with master/slave views.
// Carries classic and registered-feedback (CTI/BTE) signalling.
interface wb_if #(
  parameter int unsigned AW = 32,
  parameter int unsigned DW = 32
) ();
  logic [AW-1:0]   ADR;
  logic [DW-1:0]   DAT_W;
  logic [DW-1:0]   DAT_R;
  logic [DW/8-1:0] SEL;
  logic            CYC;
  logic            STB;
  logic            WE;
  logic [2:0]      CTI;
  logic [1:0]      BTE;
  logic            ACK;
  logic            ERR;

  modport master (
    output ADR, DAT_W, SEL, CYC, STB, WE, CTI, BTE,
    input  DAT_R, ACK, ERR
  );

  modport slave (
    input  ADR, DAT_W, SEL, CYC, STB, WE, CTI, BTE,
    output DAT_R, ACK, ERR
  );
endinterface

// File: rtl/wb_sram_slave.sv
// Wishbone B4 SRAM responder: classic cycles and CTI/BTE bursts, byte lanes.
// Define WB_SRAM_SLAVE_ERR_EN to answer out-of-window beat-0 addresses with ERR.
module wb_sram_slave #(
  parameter int unsigned WB_ADDR_WIDTH = 32,
  parameter int unsigned WB_DATA_WIDTH = 32,
  parameter int unsigned DEPTH = 1024,
  parameter logic [WB_ADDR_WIDTH-1:0] BASE_ADDR = '0
) (
  input logic clk,
  input logic rstn,
  wb_if.slave t
);
  localparam int unsigned NB = WB_DATA_WIDTH / 8;
  localparam int unsigned AL = $clog2(NB);
  localparam int unsigned IW = $clog2(DEPTH);

  typedef logic [IW-1:0] idx_t;
  typedef enum logic [1:0] {IDLE, SINGLE, BURST} state_e;

  state_e state_q, state_d;
  logic ack_q, ack_d;
  logic err_q, err_d;
  logic [WB_DATA_WIDTH-1:0] dat_q, dat_d;
  idx_t addr_q, addr_d;
  idx_t cnt_q, cnt_d;
  logic [1:0] bte_q, bte_d;

  logic [WB_DATA_WIDTH-1:0] mem [DEPTH];

  logic [WB_ADDR_WIDTH-1:0] off;
  idx_t adr_idx;
  idx_t raddr;
  logic req;
  logic beat;
  logic wr_en;
  logic last;
  logic in_range;
  logic unused_ok;
  logic [WB_DATA_WIDTH-1:0] rdata;

  // Burst address step: wrap modes roll only the low bits.
  function automatic idx_t next_idx(idx_t i, logic [1:0] bte);
    idx_t n;
    n = i;
    unique case (bte)
      2'b01: n[1:0] = i[1:0] + 2'd1;
      2'b10: n[2:0] = i[2:0] + 3'd1;
      2'b11: n[3:0] = i[3:0] + 4'd1;
      default: n = i + idx_t'(1);
    endcase
    return n;
  endfunction

  assign off = t.ADR - BASE_ADDR;
  assign adr_idx = off[AL +: IW];
  assign unused_ok = ^off;
  assign req = t.CYC & t.STB;
  assign beat = ack_q & req;
  assign wr_en = beat & t.WE;
  assign last = (t.CTI == 3'b111) || (t.CTI == 3'b000);

`ifdef WB_SRAM_SLAVE_ERR_EN
  assign in_range = ~|off[WB_ADDR_WIDTH-1:AL+IW];
  assign t.ERR = err_q;
`else
  assign in_range = 1'b1;
  assign t.ERR = 1'b0;
`endif

  assign t.ACK = ack_q;
  assign t.DAT_R = dat_q;

  always_comb begin
    state_d = state_q;
    ack_d = 1'b0;
    err_d = 1'b0;
    addr_d = addr_q;
    cnt_d = cnt_q;
    bte_d = bte_q;
    raddr = addr_q;
    unique case (state_q)
      IDLE: begin
        // err_q set means the master is still holding the errored request
        if (req && !err_q) begin
          raddr = adr_idx;
          addr_d = adr_idx;
          bte_d = t.BTE;
          cnt_d = next_idx(adr_idx, t.BTE);
          if (!in_range) begin
            err_d = 1'b1;
          end else begin
            ack_d = 1'b1;
            state_d = (t.CTI == 3'b010) ? BURST : SINGLE;
          end
        end
      end
      SINGLE: state_d = IDLE;
      BURST: begin
        if (!t.CYC) begin
          state_d = IDLE;
        end else if (beat) begin
          if (last) begin
            state_d = IDLE;
          end else begin
            raddr = cnt_q;
            addr_d = cnt_q;
            cnt_d = next_idx(cnt_q, bte_q);
            ack_d = 1'b1;
          end
        end else begin
          // pending beat not taken: re-present it once STB is back
          ack_d = t.STB;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    rdata = mem[raddr];
    if (wr_en && raddr == addr_q) begin
      for (int i = 0; i < NB; i++) begin
        if (t.SEL[i]) rdata[8*i +: 8] = t.DAT_W[8*i +: 8];
      end
    end
    dat_d = ack_d ? rdata : '0;
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int i = 0; i < NB; i++) begin
        if (t.SEL[i]) mem[addr_q][8*i +: 8] <= t.DAT_W[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= IDLE;
      ack_q <= 1'b0;
      err_q <= 1'b0;
      dat_q <= '0;
      addr_q <= '0;
      cnt_q <= '0;
      bte_q <= '0;
    end else begin
      state_q <= state_d;
      ack_q <= ack_d;
      err_q <= err_d;
      dat_q <= dat_d;
      addr_q <= addr_d;
      cnt_q <= cnt_d;
      bte_q <= bte_d;
    end
  end
endmodule

// File: tb/tb_wb_sram_slave.sv
// Bench for wb_sram_slave: table-driven classic cycles, burst sequences,
// scoreboard of expected read data, mid-burst reset.
module tb_wb_sram_slave;
  localparam logic [31:0] BASE = 32'h1000;
  localparam int DEPTH = 64;

  logic clk;
  logic rstn;
  int n_chk;
  int n_fail;
  logic [31:0] sb_q [$];

  wb_if #(.AW(32), .DW(32)) bus ();

  wb_sram_slave #(
    .WB_ADDR_WIDTH(32),
    .WB_DATA_WIDTH(32),
    .DEPTH(DEPTH),
    .BASE_ADDR(BASE)
  ) dut (
    .clk(clk),
    .rstn(rstn),
    .t(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic        we;
    int          word;
    logic [31:0] wd;
    logic [3:0]  sel;
    logic [31:0] exp;
  } vec_t;

  function automatic void check(input string nm, input logic [31:0] act,
                                input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endfunction

  function automatic void sb_pop_check(input string nm);
    logic [31:0] e;
    if (sb_q.size() == 0) begin
      n_chk++;
      n_fail++;
      $display("FAIL %s: got %h expected <none queued>", nm, bus.DAT_R);
    end else begin
      e = sb_q.pop_front();
      check(nm, bus.DAT_R, e);
    end
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic classic(input logic we, input logic [31:0] adr,
                         input logic [31:0] wd, input logic [3:0] sel,
                         input logic [31:0] exp, input logic exp_err);
    int lat;
    if (!we && !exp_err) sb_q.push_back(exp);
    bus.ADR = adr;
    bus.DAT_W = wd;
    bus.SEL = sel;
    bus.WE = we;
    bus.CTI = 3'b000;
    bus.BTE = 2'b00;
    bus.CYC = 1'b1;
    bus.STB = 1'b1;
    lat = 0;
    do begin
      tick();
      lat++;
    end while (!bus.ACK && !bus.ERR && lat < 8);
    check("classic_lat", lat, 1);
    check("classic_ack", {31'd0, bus.ACK}, {31'd0, !exp_err});
    check("classic_err", {31'd0, bus.ERR}, {31'd0, exp_err});
    if (bus.ACK && !we) sb_pop_check("classic_rd");
    else if (!we && !exp_err && sb_q.size() > 0) sb_q.pop_back();
    if (bus.ERR) check("err_dat", bus.DAT_R, 32'h0);
    tick();
    bus.CYC = 1'b0;
    bus.STB = 1'b0;
    check("classic_end", {30'd0, bus.ACK, bus.ERR}, 32'h0);
  endtask

  task automatic burst(input logic we, input int start, input logic [1:0] bte,
                       input int n, input logic [31:0] wd [8],
                       input int gap_at, input int gap_len);
    int k;
    int cyc;
    int gaps;
    k = 0;
    cyc = 0;
    gaps = 0;
    bus.ADR = BASE + 32'(start * 4);
    bus.WE = we;
    bus.SEL = 4'hF;
    bus.BTE = bte;
    bus.CTI = (n == 1) ? 3'b111 : 3'b010;
    bus.DAT_W = wd[0];
    bus.CYC = 1'b1;
    bus.STB = 1'b1;
    while (k < n && cyc < 40) begin
      tick();
      cyc++;
      bus.ADR = BASE + 32'h3C;
      if (k == gap_at && gaps < gap_len) begin
        bus.STB = 1'b0;
        gaps++;
      end else begin
        bus.STB = 1'b1;
      end
      bus.CTI = (k == n - 1) ? 3'b111 : 3'b010;
      bus.DAT_W = wd[k];
      if (bus.ACK && bus.STB) begin
        if (!we) sb_pop_check("burst_rd");
        k++;
      end
    end
    check("burst_beats", k, n);
    check("burst_cycles", cyc, n + ((gap_len > 0) ? gap_len + 1 : 0));
    tick();
    check("burst_end_ack", {31'd0, bus.ACK}, 32'h0);
    bus.CYC = 1'b0;
    bus.STB = 1'b0;
  endtask

  vec_t tbl [20];
  logic [31:0] bd [8];

  initial begin
    n_chk = 0;
    n_fail = 0;
    rstn = 1'b0;
    bus.ADR = '0;
    bus.DAT_W = '0;
    bus.SEL = '0;
    bus.CYC = 1'b0;
    bus.STB = 1'b0;
    bus.WE = 1'b0;
    bus.CTI = '0;
    bus.BTE = '0;
    for (int i = 0; i < 8; i++) bd[i] = '0;

    tbl[0]  = '{1'b1, 2,  32'hDEADBEEF, 4'hF, 32'h0};
    tbl[1]  = '{1'b0, 2,  32'h0,        4'hF, 32'hDEADBEEF};
    tbl[2]  = '{1'b1, 3,  32'hFFFFFFFF, 4'hF, 32'h0};
    tbl[3]  = '{1'b1, 3,  32'h11223344, 4'h5, 32'h0};
    tbl[4]  = '{1'b0, 3,  32'h0,        4'hF, 32'hFF22FF44};
    tbl[5]  = '{1'b1, 63, 32'hA5A5A5A5, 4'hF, 32'h0};
    tbl[6]  = '{1'b0, 63, 32'h0,        4'hF, 32'hA5A5A5A5};
    tbl[7]  = '{1'b1, 0,  32'h12345678, 4'hF, 32'h0};
    tbl[8]  = '{1'b1, 1,  32'h00000000, 4'hF, 32'h0};
    tbl[9]  = '{1'b1, 1,  32'hABCDEF01, 4'hA, 32'h0};
    tbl[10] = '{1'b0, 1,  32'h0,        4'hF, 32'hAB00EF00};
    tbl[11] = '{1'b0, 0,  32'h0,        4'hF, 32'h12345678};
    tbl[12] = '{1'b1, 62, 32'h62626262, 4'hF, 32'h0};
    tbl[13] = '{1'b1, 14, 32'h14141414, 4'hF, 32'h0};
    tbl[14] = '{1'b1, 15, 32'h15151515, 4'hF, 32'h0};
    tbl[15] = '{1'b1, 8,  32'h08080808, 4'hF, 32'h0};
    tbl[16] = '{1'b1, 9,  32'h09090909, 4'hF, 32'h0};
    tbl[17] = '{1'b1, 5,  32'h05050505, 4'hF, 32'h0};
    tbl[18] = '{1'b1, 6,  32'h06060606, 4'hF, 32'h0};
    tbl[19] = '{1'b1, 7,  32'h07070707, 4'hF, 32'h0};

    tick();
    tick();
    check("rst_ack", {31'd0, bus.ACK}, 32'h0);
    check("rst_err", {31'd0, bus.ERR}, 32'h0);
    check("rst_dat", bus.DAT_R, 32'h0);
    rstn = 1'b1;
    tick();

    for (int i = 0; i < 20; i++) begin
      classic(tbl[i].we, BASE + 32'(tbl[i].word * 4), tbl[i].wd,
              tbl[i].sel, tbl[i].exp, 1'b0);
    end

    // linear read burst from word 5
    sb_q.push_back(32'h05050505);
    sb_q.push_back(32'h06060606);
    sb_q.push_back(32'h07070707);
    sb_q.push_back(32'h08080808);
    burst(1'b0, 5, 2'b00, 4, bd, -1, 0);

    // wrap8 read from word 14
    sb_q.push_back(32'h14141414);
    sb_q.push_back(32'h15151515);
    sb_q.push_back(32'h08080808);
    sb_q.push_back(32'h09090909);
    burst(1'b0, 14, 2'b10, 4, bd, -1, 0);

    // linear read across the top of the window
    sb_q.push_back(32'h62626262);
    sb_q.push_back(32'hA5A5A5A5);
    sb_q.push_back(32'h12345678);
    burst(1'b0, 62, 2'b00, 3, bd, -1, 0);

    // wrap4 write from word 6 with a 2-clock STB gap
    bd[0] = 32'hAAAA000A;
    bd[1] = 32'hBBBB000B;
    bd[2] = 32'hCCCC000C;
    bd[3] = 32'hDDDD000D;
    burst(1'b1, 6, 2'b01, 4, bd, 2, 2);
    classic(1'b0, BASE + 32'd16, 0, 4'hF, 32'hCCCC000C, 1'b0);
    classic(1'b0, BASE + 32'd20, 0, 4'hF, 32'hDDDD000D, 1'b0);
    classic(1'b0, BASE + 32'd24, 0, 4'hF, 32'hAAAA000A, 1'b0);
    classic(1'b0, BASE + 32'd28, 0, 4'hF, 32'hBBBB000B, 1'b0);
    classic(1'b0, BASE + 32'd32, 0, 4'hF, 32'h08080808, 1'b0);

`ifdef WB_SRAM_SLAVE_ERR_EN
    classic(1'b0, BASE + 32'd256, 0, 4'hF, 32'h0, 1'b1);
    classic(1'b1, BASE + 32'd256, 32'hFFFFFFFF, 4'hF, 32'h0, 1'b1);
    classic(1'b0, BASE, 0, 4'hF, 32'h12345678, 1'b0);
`else
    classic(1'b0, BASE + 32'd256, 0, 4'hF, 32'h12345678, 1'b0);
    classic(1'b0, BASE - 32'd4, 0, 4'hF, 32'hA5A5A5A5, 1'b0);
`endif

    // reset during beat 2 of an 8-beat write burst
    for (int i = 0; i < 8; i++) begin
      classic(1'b1, BASE + 32'((20 + i) * 4), 32'hC0DE0000 + 32'(i),
              4'hF, 32'h0, 1'b0);
    end
    bus.ADR = BASE + 32'd80;
    bus.WE = 1'b1;
    bus.SEL = 4'hF;
    bus.CTI = 3'b010;
    bus.BTE = 2'b00;
    bus.DAT_W = 32'hBEEF0000;
    bus.CYC = 1'b1;
    bus.STB = 1'b1;
    tick();
    check("rb_beat0_ack", {31'd0, bus.ACK}, 32'h1);
    tick();
    bus.DAT_W = 32'hBEEF0001;
    check("rb_beat1_ack", {31'd0, bus.ACK}, 32'h1);
    tick();
    bus.DAT_W = 32'hBEEF0002;
    check("rb_beat2_ack", {31'd0, bus.ACK}, 32'h1);
    #2;
    rstn = 1'b0;
    #1;
    check("rb_ack_drop", {31'd0, bus.ACK}, 32'h0);
    check("rb_dat_clr", bus.DAT_R, 32'h0);
    tick();
    bus.DAT_W = 32'hBEEF0003;
    tick();
    bus.CYC = 1'b0;
    bus.STB = 1'b0;
    rstn = 1'b1;
    tick();
    for (int i = 0; i < 8; i++) begin
      classic(1'b0, BASE + 32'((20 + i) * 4), 0, 4'hF,
              (i < 2) ? 32'hBEEF0000 + 32'(i) : 32'hC0DE0000 + 32'(i),
              1'b0);
    end

    check("sb_drained", sb_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end
endmodule
